// File: rtl/updown_counter_mod.sv
// Up/down counter with programmable modulus (0..max_val), step size, synchronous
// load, wrap/saturate mode, a one-cycle terminal-count pulse and sticky ovf/unf flags.
module updown_counter_mod #(
  parameter int WIDTH     = 8,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  input  logic [WIDTH-1:0] step,
  input  logic             mode,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             ovf,
  output logic             unf
);

  localparam logic [WIDTH-1:0] RST_OUT = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] r_out;
  logic             r_tc;
  logic             r_ovf;
  logic             r_unf;

  logic [WIDTH:0]   w_sum;
  logic             w_step_legal;
  logic             w_ovf_set;
  logic             w_unf_set;
  logic [WIDTH-1:0] w_next_out;

  // Up-crossing in wrap mode: fold the excess back into 0..max_val.
  function automatic logic [WIDTH-1:0] wrap_up(input logic [WIDTH:0]   sum,
                                               input logic [WIDTH-1:0] mx);
    logic [WIDTH:0] t;
    t = sum - {1'b0, mx} - 1'b1;
    return t[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] wrap_down(input logic [WIDTH-1:0] cur,
                                                 input logic [WIDTH-1:0] stp,
                                                 input logic [WIDTH-1:0] mx);
    logic [WIDTH:0] t;
    t = {1'b0, cur} + {1'b0, mx} + 1'b1 - {1'b0, stp};
    return t[WIDTH-1:0];
  endfunction

  always_comb begin
    w_sum        = {1'b0, r_out} + {1'b0, step};
    w_step_legal = (step <= max_val);
    w_ovf_set    = 1'b0;
    w_unf_set    = 1'b0;
    w_next_out   = r_out;
    if (load) begin
      w_next_out = (load_val > max_val) ? max_val : load_val;
    end else if (en) begin
      if (r_out > max_val) begin
        // Limit lowered at runtime: clamp quietly, this is not a crossing.
        w_next_out = max_val;
      end else if (up_down) begin
        if (w_sum > {1'b0, max_val}) begin
          w_ovf_set  = 1'b1;
          w_next_out = (!mode && w_step_legal) ? wrap_up(w_sum, max_val) : max_val;
        end else begin
          w_next_out = w_sum[WIDTH-1:0];
        end
      end else begin
        if (step > r_out) begin
          w_unf_set  = 1'b1;
          w_next_out = (!mode && w_step_legal) ? wrap_down(r_out, step, max_val)
                                               : '0;
        end else begin
          w_next_out = r_out - step;
        end
      end
    end
  end

  // Flag set wins over a same-cycle clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out <= RST_OUT;
      r_tc  <= 1'b0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_out <= w_next_out;
      r_tc  <= w_ovf_set | w_unf_set;
      r_ovf <= (r_ovf & ~clr_flags) | w_ovf_set;
      r_unf <= (r_unf & ~clr_flags) | w_unf_set;
    end
  end

  assign out = r_out;
  assign tc  = r_tc;
  assign ovf = r_ovf;
  assign unf = r_unf;

endmodule

// File: tb/tb_updown_counter_mod.sv
// Bench for updown_counter_mod: directed scenarios with fixed expected values,
// then randomized traffic against an integer reference model.
module tb_updown_counter_mod;

  localparam int W  = 8;
  localparam int RV = 5;

  logic         clk = 1'b0;
  logic         reset;
  logic         en, up_down, load, mode, clr_flags;
  logic [W-1:0] load_val, max_val, step;
  logic [W-1:0] out;
  logic         tc, ovf, unf;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_out;
  bit m_tc, m_ovf, m_unf;

  updown_counter_mod #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load),
    .load_val(load_val), .max_val(max_val), .step(step), .mode(mode),
    .clr_flags(clr_flags), .out(out), .tc(tc), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_out = RV; m_tc = 0; m_ovf = 0; m_unf = 0;
  endtask

  // Spec rules in plain integer arithmetic.
  task automatic model_step();
    int mx, st, cur, nxt;
    bit o_set, u_set;
    mx = int'(max_val); st = int'(step); cur = m_out; nxt = cur;
    o_set = 0; u_set = 0;
    if (load) begin
      nxt = (int'(load_val) < mx) ? int'(load_val) : mx;
    end else if (en) begin
      if (cur > mx) nxt = mx;
      else if (up_down) begin
        if (cur + st <= mx) nxt = cur + st;
        else begin
          o_set = 1;
          nxt = (mode == 0 && st <= mx) ? (cur + st) % (mx + 1) : mx;
        end
      end else begin
        if (st <= cur) nxt = cur - st;
        else begin
          u_set = 1;
          nxt = (mode == 0 && st <= mx) ? cur + (mx + 1) - st : 0;
        end
      end
    end
    m_out = nxt;
    m_tc  = o_set | u_set;
    m_ovf = (m_ovf & ~clr_flags) | o_set;
    m_unf = (m_unf & ~clr_flags) | u_set;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en = 0; up_down = 1; load = 0; mode = 0; clr_flags = 0;
    load_val = '0; max_val = 8'd255; step = 8'd1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (out !== 8'd5 || tc !== 1'b0 || ovf !== 1'b0 || unf !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: out=%0d tc=%b ovf=%b unf=%b, required out=5 tc=0 ovf=0 unf=0",
               out, tc, ovf, unf);
    end
    reset = 1'b1;
    tick();
    n_checks++;
    if (out !== 8'd5) begin
      n_errors++;
      $display("FAIL reset_release_hold: out=%0d required 5", out);
    end
  endtask

  task automatic test_reset_mid_count();
    en = 1; up_down = 1; step = 8'd1; max_val = 8'd255; mode = 0;
    repeat (15) tick();
    n_checks++;
    if (out !== 8'd20) begin
      n_errors++;
      $display("FAIL count_to_20: out=%0d required 20", out);
    end
    #3 reset = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (out !== 8'd5 || tc !== 1'b0 || ovf !== 1'b0 || unf !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset: out=%0d tc=%b ovf=%b unf=%b, required out=5 all flags 0",
               out, tc, ovf, unf);
    end
    #2 reset = 1'b1;
    en = 0;
    tick();
    n_checks++;
    if (out !== 8'd5) begin
      n_errors++;
      $display("FAIL post_reset_no_en: out=%0d required 5", out);
    end
  endtask

  task automatic test_wrap_up();
    int exp_out [4] = '{3, 6, 9, 2};
    bit exp_tc  [4] = '{0, 0, 0, 1};
    load = 1; load_val = 8'd0; max_val = 8'd9; clr_flags = 1;
    tick();
    load = 0; clr_flags = 0; en = 1; up_down = 1; step = 8'd3; mode = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (out !== W'(exp_out[i]) || tc !== exp_tc[i]) begin
        n_errors++;
        $display("FAIL wrap_up[%0d]: out=%0d tc=%b, required out=%0d tc=%b",
                 i, out, tc, exp_out[i], exp_tc[i]);
      end
    end
    tick();
    n_checks++;
    if (out !== 8'd5 || tc !== 1'b0 || ovf !== 1'b1) begin
      n_errors++;
      $display("FAIL wrap_up_after: out=%0d tc=%b ovf=%b, required out=5 tc=0 ovf=1",
               out, tc, ovf);
    end
  endtask

  task automatic test_sat_down();
    int exp_out [3] = '{2, 0, 0};
    bit exp_tc  [3] = '{0, 1, 1};
    load = 1; load_val = 8'd6; max_val = 8'd9; clr_flags = 1;
    tick();
    load = 0; clr_flags = 0; en = 1; up_down = 0; step = 8'd4; mode = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (out !== W'(exp_out[i]) || tc !== exp_tc[i]) begin
        n_errors++;
        $display("FAIL sat_down[%0d]: out=%0d tc=%b, required out=%0d tc=%b",
                 i, out, tc, exp_out[i], exp_tc[i]);
      end
    end
    n_checks++;
    if (unf !== 1'b1 || ovf !== 1'b0) begin
      n_errors++;
      $display("FAIL sat_down_flags: unf=%b ovf=%b, required unf=1 ovf=0", unf, ovf);
    end
  endtask

  task automatic test_load_clamp();
    load = 1; en = 1; load_val = 8'd200; max_val = 8'd50;
    tick();
    n_checks++;
    if (out !== 8'd50 || tc !== 1'b0) begin
      n_errors++;
      $display("FAIL load_clamp: out=%0d tc=%b, required out=50 tc=0", out, tc);
    end
    load = 0; up_down = 1; step = 8'd1; mode = 0;
    tick();
    n_checks++;
    if (out !== 8'd0 || tc !== 1'b1 || ovf !== 1'b1) begin
      n_errors++;
      $display("FAIL clamp_then_wrap: out=%0d tc=%b ovf=%b, required out=0 tc=1 ovf=1",
               out, tc, ovf);
    end
  endtask

  task automatic test_flag_clear();
    en = 0; clr_flags = 1;
    tick();
    n_checks++;
    if (ovf !== 1'b0 || unf !== 1'b0) begin
      n_errors++;
      $display("FAIL clr_flags: ovf=%b unf=%b, required 0 0", ovf, unf);
    end
    clr_flags = 0; load = 1; load_val = 8'd50;
    tick();
    load = 0; en = 1; up_down = 1; step = 8'd1; clr_flags = 1;
    tick();
    n_checks++;
    if (ovf !== 1'b1 || tc !== 1'b1 || out !== 8'd0) begin
      n_errors++;
      $display("FAIL set_beats_clear: ovf=%b tc=%b out=%0d, required ovf=1 tc=1 out=0",
               ovf, tc, out);
    end
    clr_flags = 0;
  endtask

  task automatic test_limit_drop();
    load = 1; load_val = 8'd30; max_val = 8'd50; en = 0;
    tick();
    load = 0; max_val = 8'd10; en = 1; up_down = 1; step = 8'd1;
    tick();
    n_checks++;
    if (out !== 8'd10 || tc !== 1'b0 || ovf !== 1'b1 || unf !== 1'b0) begin
      n_errors++;
      $display("FAIL limit_drop: out=%0d tc=%b ovf=%b unf=%b, required out=10 tc=0 ovf=1 unf=0",
               out, tc, ovf, unf);
    end
    step = 8'd0;
    repeat (2) tick();
    n_checks++;
    if (out !== 8'd10 || tc !== 1'b0) begin
      n_errors++;
      $display("FAIL step_zero_hold: out=%0d tc=%b, required out=10 tc=0", out, tc);
    end
  endtask

  task automatic test_max_zero();
    max_val = 8'd0; en = 1; up_down = 1; step = 8'd5; mode = 0; clr_flags = 1;
    tick();
    n_checks++;
    if (out !== 8'd0 || tc !== 1'b0) begin
      n_errors++;
      $display("FAIL max_zero_clamp: out=%0d tc=%b, required out=0 tc=0", out, tc);
    end
    clr_flags = 0; up_down = 0; step = 8'd1;
    tick();
    n_checks++;
    if (out !== 8'd0 || tc !== 1'b1 || unf !== 1'b1) begin
      n_errors++;
      $display("FAIL max_zero_down: out=%0d tc=%b unf=%b, required out=0 tc=1 unf=1",
               out, tc, unf);
    end
  endtask

  task automatic test_wrap_big_step();
    load = 1; load_val = 8'd8; max_val = 8'd9;
    tick();
    load = 0; en = 1; up_down = 1; step = 8'd12; mode = 0;
    tick();
    n_checks++;
    if (out !== 8'd9 || tc !== 1'b1) begin
      n_errors++;
      $display("FAIL big_step_up: out=%0d tc=%b, required out=9 tc=1", out, tc);
    end
    up_down = 0; step = 8'd200;
    tick();
    n_checks++;
    if (out !== 8'd0 || tc !== 1'b1) begin
      n_errors++;
      $display("FAIL big_step_down: out=%0d tc=%b, required out=0 tc=1", out, tc);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      load      = ($urandom % 12) == 0;
      en        = ($urandom % 4) != 0;
      up_down   = $urandom % 2;
      mode      = $urandom % 2;
      clr_flags = ($urandom % 10) == 0;
      load_val  = W'($urandom);
      if (($urandom % 10) == 0)
        max_val = (($urandom % 8) == 0) ? 8'd0 : W'($urandom);
      step = (($urandom % 4) == 0) ? W'($urandom) : W'($urandom % 5);
      tick();
      n_checks++;
      if (out !== W'(m_out) || tc !== m_tc || ovf !== m_ovf || unf !== m_unf) begin
        n_errors++;
        $display("FAIL random[%0d]: out=%0d tc=%b ovf=%b unf=%b, required out=%0d tc=%b ovf=%b unf=%b",
                 i, out, tc, ovf, unf, m_out, m_tc, m_ovf, m_unf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_count();
    test_wrap_up();
    test_sat_down();
    test_load_clamp();
    test_flag_clear();
    test_limit_drop();
    test_max_zero();
    test_wrap_big_step();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/updown_counter_mod.md
# updown_counter_mod

Parametrised up/down counter with programmable modulus, step size, synchronous load, and wrap or saturate mode. It generalises the single-bit up/down counter into a WIDTH-bit block with terminal-count and sticky overflow/underflow flags. It sits in the counter library as the general-purpose counting primitive for timers, address generators and event counters.

## Interface
- WIDTH, 8: counter, load, limit and step width.
- RESET_VAL, 0: value of out after reset; must be ≤ 2^WIDTH−1.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- en  input  1  count enable; one step per enabled cycle.
- up_down  input  1  direction: 1 = count up, 0 = count down.
- load  input  1  synchronous load of load_val; has priority over en.
- load_val  input  WIDTH  value to load.
- max_val  input  WIDTH  upper limit; legal count range is 0..max_val (modulus max_val+1).
- step  input  WIDTH  increment/decrement amount; 0 = hold.
- mode  input  1  0 = wrap, 1 = saturate.
- clr_flags  input  1  synchronous clear of ovf/unf.
- out  output  WIDTH  current count.
- tc  output  1  one-cycle terminal-count pulse on a boundary crossing.
- ovf  output  1  sticky overflow flag.
- unf  output  1  sticky underflow flag.

## Operation
- Reset (reset=0, asynchronous): out=RESET_VAL, tc=0, ovf=0, unf=0. Outputs are held while reset=0. Release is synchronous to the next rising clk.
- Per-edge priority: load, then en, then hold.
- load=1: out <= min(load_val, max_val). tc=0. Flags unchanged except by clr_flags.
- en=1, load=0, out > max_val (max_val was lowered at runtime): out <= max_val. No tc, no flag change.
- en=1, up_down=1: sum = out + step, computed in WIDTH+1 bits.
  - sum ≤ max_val: out <= sum.
  - sum > max_val (overflow crossing):
    - wrap mode: out <= sum − (max_val+1).
    - saturate mode: out <= max_val.
    - In both modes: tc pulses and ovf is set.
- en=1, up_down=0:
  - step ≤ out: out <= out − step.
  - step > out (underflow crossing):
    - wrap mode: out <= out + (max_val+1) − step.
    - saturate mode: out <= 0.
    - In both modes: tc pulses and unf is set.
- step > max_val in wrap mode: a crossing resolves as saturate. Up gives max_val; down gives 0. Flag and tc still fire.
- step=0 with en=1: out holds, no tc, no flags.
- max_val=0: out is pinned at 0. Any nonzero step with en=1 is a crossing.
- clr_flags=1 clears ovf and unf. If a crossing occurs in the same cycle, set wins and the flag stays 1.
- Arithmetic is unsigned. No internal state beyond out, tc, ovf and unf.

## Timing
- All outputs are registered. out, tc and flags update on the same rising clk edge that samples en/load.
- Latency is 1 cycle from input to out.
- tc is high for exactly the cycle following the crossing edge. Back-to-back crossings give tc high on consecutive cycles.
- Inputs are sampled only on rising clk. max_val, step and mode may change any cycle and take effect on the edge they are sampled.
- Reset asserted mid-count clears all outputs immediately, independent of clk. The count resumes from RESET_VAL only on enabled edges after release.

## Test plan
- Reset mid-count: WIDTH=8, RESET_VAL=5, count up to 20, then pull reset low between edges -> out=5, flags=0, tc=0 immediately; first edge after release with en=0 -> out=5.
- Wrap up: max_val=9, step=3, mode=0, up from 0 -> out 3, 6, 9, 2; tc=1 only in the cycle showing 2; ovf=1 thereafter.
- Saturate down: max_val=9, step=4, mode=1, load 6, count down -> out 2, 0, 0; tc pulses twice (two crossings); unf=1.
- Load priority and clamp: load=1, en=1, load_val=200, max_val=50 -> out=50, tc=0. Then up_down=1, step=1, mode=0 -> out=0, tc=1, ovf=1.
- Flag clear vs. set: with ovf=1, assert clr_flags with no crossing -> ovf=0. Assert clr_flags in the same cycle as an up crossing -> ovf stays 1.
- Runtime limit drop: out=30, set max_val=10, en=1 -> out=10 with no tc and no flag change. step=0 with en=1 -> out holds at 10.
